traffic_led_monitor: RTL and testbench
======================================

Name: traffic_led_monitor

Overview:
- Passive checker on the receiving end of the 6-bit traffic-light LED bus driven by traffic_top.
- Samples led_output, decodes it into a phase and tracks how long each phase lasts.
- Flags illegal lamp patterns, illegal phase transitions and phases that end too early.
- Instantiated beside traffic_top in benches and on-board debug builds.

Parameters:
- MIN_GREEN, 8, minimum cycles a GO phase must last before it is left.
- MIN_YELLOW, 3, minimum cycles a WARN phase must last before it is left.
- DWELL_W, 16, width of the dwell counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- led_in  in  6  LED bus. Bits [5:3] = main {R,Y,G}; bits [2:0] = side {R,Y,G}.
- clear  in  1  synchronous clear of statistics and violation state.
- phase  out  3  decoded current phase.
- phase_change  out  1  one-cycle pulse when phase updates.
- dwell  out  DWELL_W  cycles spent in the current phase.
- last_dwell  out  DWELL_W  dwell of the previous phase.
- change_count  out  16  number of accepted phase changes (wraps).
- violation  out  1  sticky; set by the first violation.
- viol_code  out  2  code of the first violation since the last clear/reset.
- viol_count  out  8  violations seen; saturates at 255.

Behaviour:
- Reset: all outputs are 0, phase = UNKNOWN, and the input register is 0.
- Input stage: led_q <= led_in every cycle. Decode is combinational on led_q.
- Pattern decode:
  - 001100 = MAIN_GO (1)
  - 010100 = MAIN_WARN (2)
  - 100100 = ALL_RED (3)
  - 100001 = SIDE_GO (4)
  - 100010 = SIDE_WARN (5)
  - 010010 and 000000 = EMERG (6); flash on and flash off map to the same phase.
  - Any other pattern = ILLEGAL (7).
- Latency: a change on led_in appears on phase, with phase_change high, 2 cycles later.
- When decoded(led_q) == phase: no change; dwell increments, saturating at all-ones.
- When decoded(led_q) != phase:
  - phase <= decoded value.
  - phase_change = 1.
  - last_dwell <= dwell.
  - dwell <= 1.
  - change_count increments, except when leaving UNKNOWN.
- Legal transitions:
  - MAIN_GO -> MAIN_WARN
  - MAIN_WARN -> ALL_RED
  - ALL_RED -> MAIN_GO or SIDE_GO
  - SIDE_GO -> SIDE_WARN
  - SIDE_WARN -> ALL_RED
  - any legal phase -> EMERG
  - EMERG -> ALL_RED
  - UNKNOWN or ILLEGAL -> any legal phase (resync; not checked, no dwell check).
- Violation codes:
  - 1: new decoded phase is ILLEGAL.
  - 2: transition not in the legal list.
  - 3: short dwell. Leaving a GO phase with dwell < MIN_GREEN, or a WARN phase with dwell < MIN_YELLOW, on a legal non-EMERG transition. Transitions into EMERG are exempt.
- Priority: only one code per event, 1 > 2 > 3. Code 3 is evaluated only when the transition is legal.
- On a violation event:
  - viol_count increments, saturating.
  - If violation = 0: violation <= 1 and viol_code <= code.
  - If violation is already set, viol_code holds the first code.
- Repeated ILLEGAL -> ILLEGAL is not a change, so it raises no new violation.
- ILLEGAL -> different ILLEGAL pattern is also not a change, because both decode to 7.
- clear: zeroes violation, viol_code, viol_count and change_count. Phase, dwell and last_dwell continue unaffected.
- If clear coincides with a violation event: the event wins. violation = 1, viol_code = new code, viol_count = 1.
- If clear coincides with a phase change: change_count = 1.
- rst mid-operation: everything returns to reset values on the next edge. The first legal pattern afterwards is accepted as a resync without a violation.
- The block never drives the LED bus; it is purely observational.

Test Plan:
- Reset then hold led_in = 001100 for 20 cycles -> phase = 1 two cycles after rst deasserts; phase_change is a single pulse; violation = 0; change_count = 0; dwell = 18 at the end of the window.
- Full legal cycle: MAIN_GO 10 cycles, MAIN_WARN 4, ALL_RED 2, SIDE_GO 10, SIDE_WARN 4, ALL_RED 2, MAIN_GO -> change_count = 6, violation = 0, last_dwell = 2 after the final change.
- MAIN_GO for 5 cycles (MIN_GREEN = 8) then MAIN_WARN -> violation = 1, viol_code = 3, viol_count = 1.
- MAIN_GO -> SIDE_GO directly -> viol_code = 2. A following pattern 001001 (both greens) -> phase = 7, viol_count = 2, viol_code stays 2.
- From SIDE_GO after 3 cycles, alternate 010010 and 000000 every 5 cycles, then ALL_RED -> phase = 6 throughout the flashing with no phase_change between flash states; violation = 0; exit to phase = 3 is legal.
- Assert clear in the same cycle as an illegal transition is detected -> violation = 1, viol_count = 1. Assert rst mid-phase -> all outputs 0 next cycle and phase = UNKNOWN.

Source files
------------

// File: rtl/traffic_led_monitor.sv
// traffic_led_monitor
// Passive observer for the 6-bit traffic-light LED bus. It registers the bus,
// decodes it into a phase, times each phase and records the first illegal
// pattern, illegal transition or early exit from a GO/WARN phase. The block
// has no path back onto the LED bus.
module traffic_led_monitor #(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 3,
    parameter int DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         led_in,
    input  logic               clear,
    output logic [2:0]         phase,
    output logic               phase_change,
    output logic [DWELL_W-1:0] dwell,
    output logic [DWELL_W-1:0] last_dwell,
    output logic [15:0]        change_count,
    output logic               violation,
    output logic [1:0]         viol_code,
    output logic [7:0]         viol_count
);

    localparam logic [2:0] PH_UNKNOWN   = 3'd0;
    localparam logic [2:0] PH_MAIN_GO   = 3'd1;
    localparam logic [2:0] PH_MAIN_WARN = 3'd2;
    localparam logic [2:0] PH_ALL_RED   = 3'd3;
    localparam logic [2:0] PH_SIDE_GO   = 3'd4;
    localparam logic [2:0] PH_SIDE_WARN = 3'd5;
    localparam logic [2:0] PH_EMERG     = 3'd6;
    localparam logic [2:0] PH_ILLEGAL   = 3'd7;

    localparam logic [1:0] VC_NONE    = 2'd0;
    localparam logic [1:0] VC_PATTERN = 2'd1;
    localparam logic [1:0] VC_TRANS   = 2'd2;
    localparam logic [1:0] VC_SHORT   = 2'd3;

    localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] MIN_G     = DWELL_W'(MIN_GREEN);
    localparam logic [DWELL_W-1:0] MIN_Y     = DWELL_W'(MIN_YELLOW);

    // Map a lamp pattern {main RYG, side RYG} onto a phase; both emergency
    // flash states collapse onto one phase so flashing is not a change.
    function automatic logic [2:0] decode_led(input logic [5:0] led);
        logic [2:0] ph;
        case (led)
            6'b001100: ph = PH_MAIN_GO;
            6'b010100: ph = PH_MAIN_WARN;
            6'b100100: ph = PH_ALL_RED;
            6'b100001: ph = PH_SIDE_GO;
            6'b100010: ph = PH_SIDE_WARN;
            6'b010010: ph = PH_EMERG;
            6'b000000: ph = PH_EMERG;
            default:   ph = PH_ILLEGAL;
        endcase
        return ph;
    endfunction

    // Allowed successor check for a transition out of a legal phase.
    function automatic logic is_legal(input logic [2:0] from_ph, input logic [2:0] to_ph);
        logic ok;
        case (from_ph)
            PH_MAIN_GO:   ok = (to_ph == PH_MAIN_WARN) || (to_ph == PH_EMERG);
            PH_MAIN_WARN: ok = (to_ph == PH_ALL_RED)   || (to_ph == PH_EMERG);
            PH_ALL_RED:   ok = (to_ph == PH_MAIN_GO)   || (to_ph == PH_SIDE_GO) ||
                               (to_ph == PH_EMERG);
            PH_SIDE_GO:   ok = (to_ph == PH_SIDE_WARN) || (to_ph == PH_EMERG);
            PH_SIDE_WARN: ok = (to_ph == PH_ALL_RED)   || (to_ph == PH_EMERG);
            PH_EMERG:     ok = (to_ph == PH_ALL_RED);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [5:0]         led_q_r;
    logic               led_valid_r;
    logic [2:0]         phase_r;
    logic               phase_change_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] last_dwell_r;
    logic [15:0]        change_count_r;
    logic               violation_r;
    logic [1:0]         viol_code_r;
    logic [7:0]         viol_count_r;

    logic [2:0]         decoded_s;
    logic               change_s;
    logic               count_s;
    logic               short_s;
    logic [1:0]         code_s;
    logic               event_s;

    // Decode the registered bus and detect a phase change. The first sample
    // after reset is not yet valid, so the cleared register is not mistaken
    // for an emergency-off pattern.
    always_comb begin
        decoded_s = decode_led(led_q_r);
        change_s  = led_valid_r && (decoded_s != phase_r);
        count_s   = change_s && (phase_r != PH_UNKNOWN);
    end

    // Early-exit test on the phase currently being left.
    always_comb begin
        short_s = 1'b0;
        case (phase_r)
            PH_MAIN_GO, PH_SIDE_GO:     short_s = (dwell_r < MIN_G);
            PH_MAIN_WARN, PH_SIDE_WARN: short_s = (dwell_r < MIN_Y);
            default:                    short_s = 1'b0;
        endcase
    end

    // Classify a change into at most one violation code, highest priority first;
    // leaving UNKNOWN or ILLEGAL is a resync and is not checked.
    always_comb begin
        code_s = VC_NONE;
        if (!change_s) begin
            code_s = VC_NONE;
        end else if (decoded_s == PH_ILLEGAL) begin
            code_s = VC_PATTERN;
        end else if ((phase_r == PH_UNKNOWN) || (phase_r == PH_ILLEGAL)) begin
            code_s = VC_NONE;
        end else if (!is_legal(phase_r, decoded_s)) begin
            code_s = VC_TRANS;
        end else if ((decoded_s != PH_EMERG) && short_s) begin
            code_s = VC_SHORT;
        end else begin
            code_s = VC_NONE;
        end
        event_s = (code_s != VC_NONE);
    end

    // Input register and phase/dwell tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q_r        <= 6'd0;
            led_valid_r    <= 1'b0;
            phase_r        <= PH_UNKNOWN;
            phase_change_r <= 1'b0;
            dwell_r        <= {DWELL_W{1'b0}};
            last_dwell_r   <= {DWELL_W{1'b0}};
        end else begin
            led_q_r        <= led_in;
            led_valid_r    <= 1'b1;
            phase_change_r <= change_s;
            if (change_s) begin
                phase_r      <= decoded_s;
                last_dwell_r <= dwell_r;
                dwell_r      <= DWELL_ONE;
            end else if (led_valid_r && (dwell_r != DWELL_MAX)) begin
                dwell_r <= dwell_r + DWELL_ONE;
            end else begin
                dwell_r <= dwell_r;
            end
        end
    end

    // Statistics and sticky violation state; a coincident event beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            change_count_r <= 16'd0;
            violation_r    <= 1'b0;
            viol_code_r    <= VC_NONE;
            viol_count_r   <= 8'd0;
        end else begin
            if (clear) begin
                change_count_r <= count_s ? 16'd1 : 16'd0;
            end else if (count_s) begin
                change_count_r <= change_count_r + 16'd1;
            end else begin
                change_count_r <= change_count_r;
            end

            if (event_s && (clear || !violation_r)) begin
                violation_r <= 1'b1;
                viol_code_r <= code_s;
            end else if (clear) begin
                violation_r <= 1'b0;
                viol_code_r <= VC_NONE;
            end else begin
                violation_r <= violation_r;
                viol_code_r <= viol_code_r;
            end

            if (clear) begin
                viol_count_r <= event_s ? 8'd1 : 8'd0;
            end else if (event_s && (viol_count_r != 8'd255)) begin
                viol_count_r <= viol_count_r + 8'd1;
            end else begin
                viol_count_r <= viol_count_r;
            end
        end
    end

    assign phase        = phase_r;
    assign phase_change = phase_change_r;
    assign dwell        = dwell_r;
    assign last_dwell   = last_dwell_r;
    assign change_count = change_count_r;
    assign violation    = violation_r;
    assign viol_code    = viol_code_r;
    assign viol_count   = viol_count_r;

endmodule

// File: tb/tb_traffic_led_monitor.sv
// Directed bench for traffic_led_monitor: a linear sequence of LED patterns
// with hand-computed expectations checked right after each rising edge.
module tb_traffic_led_monitor;

    localparam logic [5:0] P_MG  = 6'b001100;
    localparam logic [5:0] P_MW  = 6'b010100;
    localparam logic [5:0] P_AR  = 6'b100100;
    localparam logic [5:0] P_SG  = 6'b100001;
    localparam logic [5:0] P_SW  = 6'b100010;
    localparam logic [5:0] P_EON = 6'b010010;
    localparam logic [5:0] P_EOF = 6'b000000;
    localparam logic [5:0] P_BAD = 6'b001001;
    localparam logic [5:0] P_BD2 = 6'b111111;

    logic        clk;
    logic        rst;
    logic [5:0]  led_in;
    logic        clear;
    logic [2:0]  phase;
    logic        phase_change;
    logic [15:0] dwell;
    logic [15:0] last_dwell;
    logic [15:0] change_count;
    logic        violation;
    logic [1:0]  viol_code;
    logic [7:0]  viol_count;

    int checks = 0;
    int errors = 0;

    traffic_led_monitor #(.MIN_GREEN(8), .MIN_YELLOW(3), .DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .clear(clear),
        .phase(phase), .phase_change(phase_change), .dwell(dwell),
        .last_dwell(last_dwell), .change_count(change_count),
        .violation(violation), .viol_code(viol_code), .viol_count(viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a pattern and hold it for n edges (phase then lasts n cycles).
    task automatic hold(input logic [5:0] pat, input int n);
        led_in = pat;
        step(n);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; led_in = P_MG;
        step(3);
        chk("rst_phase", phase, 0);
        chk("rst_pc", phase_change, 0);
        chk("rst_dwell", dwell, 0);
        chk("rst_ccount", change_count, 0);
        chk("rst_viol", violation, 0);
        chk("rst_vcount", viol_count, 0);

        // Hold MAIN_GO after reset release
        rst = 1'b0;
        step(1);
        chk("lat_phase1", phase, 0);
        step(1);
        chk("lat_phase2", phase, 1);
        chk("lat_pc", phase_change, 1);
        chk("lat_dwell", dwell, 1);
        step(1);
        chk("pc_single", phase_change, 0);
        step(16);
        chk("hold_dwell", dwell, 18);
        chk("hold_ccount", change_count, 0);
        chk("hold_viol", violation, 0);

        // Full legal cycle
        hold(P_MW, 4);
        chk("cyc_mw", phase, 2);
        hold(P_AR, 2);
        hold(P_SG, 10);
        chk("cyc_sg", phase, 4);
        hold(P_SW, 4);
        hold(P_AR, 2);
        hold(P_MG, 2);
        chk("cyc_phase", phase, 1);
        chk("cyc_pc", phase_change, 1);
        chk("cyc_ccount", change_count, 6);
        chk("cyc_last", last_dwell, 2);
        chk("cyc_viol", violation, 0);

        // MAIN_GO lasting 5 cycles, then MAIN_WARN: short green
        step(3);
        hold(P_MW, 2);
        chk("short_phase", phase, 2);
        chk("short_viol", violation, 1);
        chk("short_code", viol_code, 3);
        chk("short_cnt", viol_count, 1);
        chk("short_last", last_dwell, 5);

        // clear with no coincident event
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_viol", violation, 0);
        chk("clr_code", viol_code, 0);
        chk("clr_vcount", viol_count, 0);
        chk("clr_ccount", change_count, 0);
        chk("clr_phase", phase, 2);
        step(3);

        // MAIN_GO -> SIDE_GO is not allowed
        hold(P_AR, 2);
        hold(P_MG, 10);
        chk("pre_tr_viol", violation, 0);
        hold(P_SG, 2);
        chk("tr_phase", phase, 4);
        chk("tr_viol", violation, 1);
        chk("tr_code", viol_code, 2);
        chk("tr_cnt", viol_count, 1);
        hold(P_BAD, 2);
        chk("ill_phase", phase, 7);
        chk("ill_cnt", viol_count, 2);
        chk("ill_code", viol_code, 2);
        hold(P_BD2, 2);
        chk("ill2_pc", phase_change, 0);
        chk("ill2_phase", phase, 7);
        chk("ill2_cnt", viol_count, 2);

        // Resync to SIDE_GO under clear, then emergency flashing
        led_in = P_SG; clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
        chk("rsy_phase", phase, 4);
        chk("rsy_viol", violation, 0);
        step(1);
        hold(P_EON, 2);
        chk("em_phase", phase, 6);
        chk("em_pc", phase_change, 1);
        chk("em_viol", violation, 0);
        step(3);
        hold(P_EOF, 1);
        chk("emf_pc_a", phase_change, 0);
        chk("emf_phase_a", phase, 6);
        step(1);
        chk("emf_pc_b", phase_change, 0);
        chk("emf_phase_b", phase, 6);
        step(3);
        hold(P_EON, 2);
        chk("emf_pc_c", phase_change, 0);
        chk("emf_phase_c", phase, 6);
        chk("emf_dwell", dwell, 11);
        step(3);
        hold(P_AR, 2);
        chk("emx_phase", phase, 3);
        chk("emx_pc", phase_change, 1);
        chk("emx_viol", violation, 0);
        chk("emx_vcount", viol_count, 0);
        chk("emx_last", last_dwell, 15);
        chk("emx_ccount", change_count, 3);

        // ALL_RED -> SIDE_WARN detected in the same cycle as clear
        step(2);
        led_in = P_SW;
        step(1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("cev_phase", phase, 5);
        chk("cev_viol", violation, 1);
        chk("cev_code", viol_code, 2);
        chk("cev_vcount", viol_count, 1);
        chk("cev_ccount", change_count, 1);

        // Reset in the middle of a phase
        step(3);
        rst = 1'b1;
        step(1);
        chk("mrst_phase", phase, 0);
        chk("mrst_viol", violation, 0);
        chk("mrst_vcount", viol_count, 0);
        chk("mrst_dwell", dwell, 0);
        chk("mrst_last", last_dwell, 0);
        chk("mrst_ccount", change_count, 0);
        rst = 1'b0;
        step(2);
        chk("mres_phase", phase, 5);
        chk("mres_viol", violation, 0);
        chk("mres_ccount", change_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
